// File: rtl/free_list_ctrl.sv
// Free-list controller for packet-memory blocks: a circular FIFO of free block
// indices, self-populated after reset, with registered allocation grants.
module free_list_ctrl #(
  parameter int ADDR_W     = 8,
  parameter int NUM_BLOCKS = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fl_alloc_req_i,
  output logic              fl_alloc_gnt_o,
  output logic [ADDR_W-1:0] fl_alloc_block_idx_o,
  input  logic              free_req_i,
  input  logic [ADDR_W-1:0] free_block_idx_i,
  output logic              init_done_o,
  output logic [ADDR_W:0]   free_count_o,
  output logic              empty_o,
  output logic              err_o
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_BLOCKS - 1);
  localparam logic [ADDR_W:0]   FULL_CNT = (ADDR_W + 1)'(NUM_BLOCKS);
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W + 1)'(1);

  typedef enum logic {INIT, RUN} state_t;

  state_t              state_reg, state_next;
  logic [ADDR_W-1:0]   rd_ptr_reg, wr_ptr_reg;
  logic [ADDR_W:0]     count_reg;
  logic [ADDR_W-1:0]   mem [NUM_BLOCKS];
  logic                pop, push, bad_free, wr_en;
  logic [ADDR_W-1:0]   wr_data;

  function automatic logic [ADDR_W-1:0] ptr_inc(input logic [ADDR_W-1:0] p);
    return (p == LAST_IDX) ? '0 : p + ADDR_W'(1);
  endfunction

  // During INIT the write pointer doubles as the index being seeded.
  always_comb begin
    state_next = state_reg;
    pop        = 1'b0;
    push       = 1'b0;
    bad_free   = 1'b0;
    wr_en      = 1'b0;
    wr_data    = wr_ptr_reg;
    case (state_reg)
      INIT: begin
        wr_en = 1'b1;
        if (wr_ptr_reg == LAST_IDX) state_next = RUN;
      end
      RUN: begin
        pop = fl_alloc_req_i && (count_reg != '0);
        if (free_req_i) begin
          if ((count_reg == FULL_CNT) || ({1'b0, free_block_idx_i} >= FULL_CNT))
            bad_free = 1'b1;
          else
            push = 1'b1;
        end
        wr_en   = push;
        wr_data = free_block_idx_i;
      end
      default: state_next = INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg            <= INIT;
      rd_ptr_reg           <= '0;
      wr_ptr_reg           <= '0;
      count_reg            <= '0;
      init_done_o          <= 1'b0;
      fl_alloc_gnt_o       <= 1'b0;
      fl_alloc_block_idx_o <= '0;
      err_o                <= 1'b0;
    end else begin
      state_reg      <= state_next;
      init_done_o    <= (state_next == RUN);
      fl_alloc_gnt_o <= pop;
      err_o          <= err_o | bad_free;
      if (pop) begin
        fl_alloc_block_idx_o <= mem[rd_ptr_reg];
        rd_ptr_reg           <= ptr_inc(rd_ptr_reg);
      end
      if (wr_en) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      case ({wr_en, pop})
        2'b10:   count_reg <= count_reg + CNT_ONE;
        2'b01:   count_reg <= count_reg - CNT_ONE;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Storage is not reset; a write never targets the head of a non-empty list,
  // so a same-edge pop always reads an older entry.
  always_ff @(posedge clk) begin
    if (wr_en && !rst) mem[wr_ptr_reg] <= wr_data;
  end

  assign free_count_o = count_reg;
  assign empty_o      = (count_reg == '0);

endmodule
